svm_request_scheduler: RTL and testbench
========================================

// Module: svm_request_scheduler
// PURPOSE
// - Shares one SVM classifier core among NREQ feature sources, e.g. per-sensor window extractors.
// - Round-robin arbiter picks one source at a time and registers its feature vector.
// - Issues the vector on the core fin_valid/fin_ready handshake and waits for the core's dout.
// - Returns valence/arousal tagged with the source id. The core is single-issue, so at most one request is in flight.
// PARAMETERS
// NBITS        `NBITS   bits per quantized feature (signed)
// F_WIDTH      `F_WIDTH features per vector
// NREQ         4        number of requesters (>=2)
// LOG_NREQ     `ceilLog2(NREQ)  id width
// LAT_WIDTH    16       width of latency counter
// WDOG_CYCLES  4096     watchdog limit, cycles (SVM_WDOG_EN only)
// PORTS
// clk             in   1                    clock
// rst             in   1                    reset, asynchronous, active-low
// req_valid       in   NREQ                 per-source request valid
// req_ready       out  NREQ                 per-source accept, one-hot, one cycle
// req_features    in   NREQ*NBITS*F_WIDTH   source i at [i*NBITS*F_WIDTH +: NBITS*F_WIDTH]
// core_features   out  NBITS*F_WIDTH        registered vector to core in_features
// core_fin_valid  out  1                    to core fin_valid
// core_fin_ready  in   1                    from core fin_ready
// core_valence    in   1                    from core
// core_arousal    in   1                    from core
// core_dout_valid in   1                    from core
// core_dout_ready out  1                    to core dout_ready
// res_valid       out  1                    result valid
// res_ready       in   1                    result consumer ready
// res_id          out  LOG_NREQ             source id of result
// res_valence     out  1                    classified valence
// res_arousal     out  1                    classified arousal
// res_timeout     out  1                    result is a watchdog abort (0 when SVM_WDOG_EN undefined)
// busy            out  1                    state != IDLE
// last_latency    out  LAT_WIDTH            cycles from fin handshake to dout handshake, last request
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset values: all outputs 0, state=IDLE, rr_ptr=0. core_features is cleared, as are the internal id, stale flag and counters.
// - The core shares rst; reset mid-operation aborts the in-flight request silently, with no response.
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE: search req_valid from rr_ptr upward, wrapping modulo NREQ; the first set bit i wins.
//   Same cycle: req_ready[i]=1 (combinational on req_valid and state), latch req_features slice i and id=i.
//   Then rr_ptr <= (i+1)%NREQ and -> ISSUE. No valid bit set -> stay in IDLE, req_ready=0.
// - ISSUE: core_fin_valid=1 and core_features held stable until core_fin_ready=1.
//   On that handshake: lat_cnt<=0 -> WAIT. No min latency from IDLE accept to fin_valid: 1 cycle.
// - WAIT: core_dout_ready=1; lat_cnt increments, saturating at 2^LAT_WIDTH-1.
//   On core_dout_valid: capture valence/arousal, last_latency<=lat_cnt+1 (saturated) -> RESP.
// - RESP: res_valid=1 with res_id/res_valence/res_arousal stable until res_ready=1.
//   On the handshake -> IDLE; a new grant is possible the next cycle.
// - A result is never dropped; backpressure on res_ready stalls the scheduler, and the core is not issued.
// - Simultaneous requests: strictly round-robin. Each requester waits at most NREQ-1 other grants.
// - req_valid dropping before grant: no effect, that source is simply skipped.
// - core_dout_valid outside WAIT with no stale flag: ignored, core_dout_ready=0.
// CONFIGURATION
// - SVM_WDOG_EN defined: watchdog runs in WAIT.
//   If lat_cnt reaches WDOG_CYCLES-1 without core_dout_valid -> RESP with res_timeout=1, valence/arousal=0.
//   The stale flag is set. While the stale flag is set and state != WAIT, core_dout_ready=1.
//   The next core_dout_valid is discarded and clears the flag.
//   IDLE does not grant while the stale flag is set.
// - SVM_WDOG_EN undefined: no watchdog, WAIT waits indefinitely, res_timeout tied 0, no stale logic.
// TESTING
// - Single request: req_valid=0010, core ready, dout after 50 cycles with V=1,A=0.
//   Expect req_ready=0010 for 1 cycle, res_id=1, res_valence=1, res_arousal=0, last_latency=50.
// - All four valid continuously, res_ready=1: grant order 0,1,2,3,0.
//   Each core_features equals the granted slice.
// - rr fairness: after grant to 3, only req 0 and 2 valid -> grant 0, then 2.
// - Backpressure: res_ready=0 for 20 cycles in RESP. res_valid and res fields held, no core_fin_valid, req_ready=0.
// - core_fin_ready low for 7 cycles in ISSUE: core_fin_valid and core_features held stable; fin handshake on cycle 8.
// - SVM_WDOG_EN, WDOG_CYCLES=16: core never responds -> res_timeout=1 at WAIT cycle 16.
//   A late dout is discarded and no grant occurs meanwhile. The next request then completes normally.
//   Also: rst low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/svm_request_scheduler.sv
`timescale 1ns/1ps
// svm_request_scheduler
// Shares one single-issue SVM classifier core among NREQ feature sources.
// A round-robin arbiter grants one source, registers its feature vector,
// issues it to the core, waits for the classification and returns it tagged
// with the source id. Optional watchdog: define SVM_WDOG_EN.
//
// Handshake rule used on every valid/ready pair in this block: a transfer
// happens on a rising clock edge where valid and ready are both 1; once a
// sender raises valid it holds valid and its payload stable until that edge.
module svm_request_scheduler #(
    parameter int NBITS       = 8,
    parameter int F_WIDTH     = 4,
    parameter int NREQ        = 4,
    parameter int LOG_NREQ    = $clog2(NREQ),
    parameter int LAT_WIDTH   = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*NBITS*F_WIDTH-1:0] req_features,
    output logic [NBITS*F_WIDTH-1:0]      core_features,
    output logic                          core_fin_valid,
    input  logic                          core_fin_ready,
    input  logic                          core_valence,
    input  logic                          core_arousal,
    input  logic                          core_dout_valid,
    output logic                          core_dout_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [LOG_NREQ-1:0]           res_id,
    output logic                          res_valence,
    output logic                          res_arousal,
    output logic                          res_timeout,
    output logic                          busy,
    output logic [LAT_WIDTH-1:0]          last_latency,
    output logic [1:0]                    state_dbg
);

    localparam int VW = NBITS * F_WIDTH;
    localparam logic [LAT_WIDTH-1:0] WDOG_LIMIT = LAT_WIDTH'(WDOG_CYCLES - 1);
`ifdef SVM_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [LOG_NREQ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LOG_NREQ-1:0]   id_q, id_d;
    logic [VW-1:0]         feat_q, feat_d;
    logic                  fin_valid_q, fin_valid_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_valence_q, res_valence_d;
    logic                  res_arousal_q, res_arousal_d;
    logic                  res_timeout_q, res_timeout_d;
    logic [LAT_WIDTH-1:0]  lat_cnt_q, lat_cnt_d;
    logic [LAT_WIDTH-1:0]  last_lat_q, last_lat_d;
    // Set after a watchdog abort: the core still owes one dout for it.
    logic                  stale_q, stale_d;

    logic                  grant_hit;
    logic [LOG_NREQ-1:0]   grant_idx;
    logic                  can_grant;
    logic [LAT_WIDTH-1:0]  lat_inc;
    logic                  wdog_hit;

    // Round-robin search: first valid source at or above rr_ptr, wrapping.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_hit && req_valid[LOG_NREQ'((int'(rr_ptr_q) + k) % NREQ)]) begin
                grant_hit = 1'b1;
                grant_idx = LOG_NREQ'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    assign can_grant = (state_q == IDLE) && grant_hit && !stale_q;
    assign lat_inc   = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + 1'b1;
    assign wdog_hit  = WDOG_EN && (lat_cnt_q == WDOG_LIMIT);

    // Next-state and datapath updates for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        feat_d        = feat_q;
        fin_valid_d   = fin_valid_q;
        res_valid_d   = res_valid_q;
        res_valence_d = res_valence_q;
        res_arousal_d = res_arousal_q;
        res_timeout_d = res_timeout_q;
        lat_cnt_d     = lat_cnt_q;
        last_lat_d    = last_lat_q;
        stale_d       = stale_q;

        // The late dout of an aborted request is swallowed outside WAIT.
        if (stale_q && (state_q != WAIT) && core_dout_valid) begin
            stale_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (can_grant) begin
                    id_d        = grant_idx;
                    feat_d      = req_features[grant_idx*VW +: VW];
                    rr_ptr_d    = (grant_idx == LOG_NREQ'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    fin_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (core_fin_ready) begin
                    fin_valid_d = 1'b0;
                    lat_cnt_d   = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (core_dout_valid) begin
                    res_valid_d   = 1'b1;
                    res_valence_d = core_valence;
                    res_arousal_d = core_arousal;
                    res_timeout_d = 1'b0;
                    last_lat_d    = lat_inc;
                    state_d       = RESP;
                end else if (wdog_hit) begin
                    res_valid_d   = 1'b1;
                    res_valence_d = 1'b0;
                    res_arousal_d = 1'b0;
                    res_timeout_d = 1'b1;
                    stale_d       = 1'b1;
                    state_d       = RESP;
                end else begin
                    lat_cnt_d = lat_inc;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            feat_q        <= '0;
            fin_valid_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_valence_q <= 1'b0;
            res_arousal_q <= 1'b0;
            res_timeout_q <= 1'b0;
            lat_cnt_q     <= '0;
            last_lat_q    <= '0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            feat_q        <= feat_d;
            fin_valid_q   <= fin_valid_d;
            res_valid_q   <= res_valid_d;
            res_valence_q <= res_valence_d;
            res_arousal_q <= res_arousal_d;
            res_timeout_q <= res_timeout_d && WDOG_EN;
            lat_cnt_q     <= lat_cnt_d;
            last_lat_q    <= last_lat_d;
            stale_q       <= stale_d && WDOG_EN;
        end
    end

    // The grant strobe is forced low while reset is held so every output is 0.
    assign req_ready       = (can_grant && rst) ? (NREQ'(1) << grant_idx) : '0;
    assign core_features   = feat_q;
    assign core_fin_valid  = fin_valid_q;
    assign core_dout_ready = (state_q == WAIT) || stale_q;
    assign res_valid       = res_valid_q;
    assign res_id          = id_q;
    assign res_valence     = res_valence_q;
    assign res_arousal     = res_arousal_q;
    assign res_timeout     = res_timeout_q;
    assign busy            = (state_q != IDLE);
    assign last_latency    = last_lat_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_svm_request_scheduler.sv
`timescale 1ns/1ps
// Directed bench for svm_request_scheduler; the bench plays the core and the
// result consumer. Build with SVM_WDOG_EN defined to also cover the watchdog.
module tb_svm_request_scheduler;

    localparam int NBITS = 8;
    localparam int F_WIDTH = 4;
    localparam int NREQ = 4;
    localparam int LOG_NREQ = 2;
    localparam int LAT_WIDTH = 16;
    localparam int VW = NBITS * F_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*VW-1:0]     req_features = '0;
    logic [VW-1:0]          core_features;
    logic                   core_fin_valid;
    logic                   core_fin_ready = 1'b0;
    logic                   core_valence = 1'b0;
    logic                   core_arousal = 1'b0;
    logic                   core_dout_valid = 1'b0;
    logic                   core_dout_ready;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [LOG_NREQ-1:0]    res_id;
    logic                   res_valence;
    logic                   res_arousal;
    logic                   res_timeout;
    logic                   busy;
    logic [LAT_WIDTH-1:0]   last_latency;
    logic [1:0]             state_dbg;

    logic [VW-1:0]          feat_tab [NREQ];
    logic [LOG_NREQ-1:0]    exp_q[$];
    int                     n_vec = 0;
    int                     n_miss = 0;

    svm_request_scheduler #(
        .NBITS(NBITS), .F_WIDTH(F_WIDTH), .NREQ(NREQ), .LOG_NREQ(LOG_NREQ),
        .LAT_WIDTH(LAT_WIDTH), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_features(req_features),
        .core_features(core_features), .core_fin_valid(core_fin_valid),
        .core_fin_ready(core_fin_ready), .core_valence(core_valence),
        .core_arousal(core_arousal), .core_dout_valid(core_dout_valid),
        .core_dout_ready(core_dout_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_valence(res_valence), .res_arousal(res_arousal),
        .res_timeout(res_timeout), .busy(busy), .last_latency(last_latency),
        .state_dbg(state_dbg)
    );

    // Clock and overall time limit.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL time_limit: got no finish, expected finish before 500000ns");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_features();
        for (int i = 0; i < NREQ; i++) req_features[i*VW +: VW] = feat_tab[i];
    endtask

    // Called in an IDLE cycle where source id must win; plays the core through
    // one full request and checks everything the scheduler shows on the way.
    task automatic serve_core(input int id, input int fin_stall, input int lat,
                              input logic v, input logic a, input int resp_stall);
        logic [VW-1:0] ef;
        ef = feat_tab[id];
        core_fin_ready = 1'b0;
        #1;
        chk("grant", 64'(req_ready), 64'(1) << id);
        tick();
        chk("issue_fin_valid", 64'(core_fin_valid), 64'd1);
        chk("issue_features", 64'(core_features), 64'(ef));
        chk("issue_req_ready", 64'(req_ready), 64'd0);
        for (int s = 0; s < fin_stall; s++) begin
            req_features = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("stall_fin_valid", 64'(core_fin_valid), 64'd1);
            chk("stall_features", 64'(core_features), 64'(ef));
        end
        load_features();
        core_fin_ready = 1'b1;
        tick();
        core_fin_ready = 1'b0;
        chk("wait_fin_valid", 64'(core_fin_valid), 64'd0);
        chk("wait_dout_ready", 64'(core_dout_ready), 64'd1);
        if (resp_stall > 0) res_ready = 1'b0;
        repeat (lat - 1) tick();
        core_dout_valid = 1'b1;
        core_valence = v;
        core_arousal = a;
        tick();
        core_dout_valid = 1'b0;
        core_valence = 1'b0;
        core_arousal = 1'b0;
        chk("res_valid", 64'(res_valid), 64'd1);
        chk("res_id", 64'(res_id), 64'(id));
        chk("res_valence", 64'(res_valence), 64'(v));
        chk("res_arousal", 64'(res_arousal), 64'(a));
        chk("res_timeout", 64'(res_timeout), 64'd0);
        chk("last_latency", 64'(last_latency), 64'(lat));
        chk("resp_dout_ready", 64'(core_dout_ready), 64'd0);
        for (int s = 0; s < resp_stall; s++) begin
            tick();
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_res_fields", {62'(res_id), res_valence, res_arousal},
                {62'(id), v, a});
            chk("bp_fin_valid", 64'(core_fin_valid), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        chk("done_res_valid", 64'(res_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_features"}, 64'(core_features), 64'd0);
        chk({tag, "_ctrl"}, {59'd0, core_fin_valid, core_dout_ready, res_valid, res_timeout, busy}, 64'd0);
        chk({tag, "_res"}, {61'd0, res_id, res_valence}, 64'd0);
        chk({tag, "_arousal"}, 64'(res_arousal), 64'd0);
        chk({tag, "_latency"}, 64'(last_latency), 64'd0);
    endtask

    initial begin
        feat_tab[0] = 32'h1122_3344;
        feat_tab[1] = 32'h5566_7788;
        feat_tab[2] = 32'h99AA_BBCC;
        feat_tab[3] = 32'hDDEE_FF01;
        load_features();

        // Reset: everything idle and zero, even with a request pending.
        req_valid = 4'b1111;
        repeat (3) tick();
        chk_all_zero("reset");
        req_valid = '0;
        rst = 1'b1;
        tick();
        chk("post_reset_busy", 64'(busy), 64'd0);

        // All four valid with res_ready high: strict rotation 0,1,2,3,0.
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_valid = 4'b1111;
        while (exp_q.size() > 0) begin
            logic [LOG_NREQ-1:0] e;
            e = exp_q.pop_front();
            serve_core(int'(e), 0, 1, e[0], e[1], 0);
        end

        // Single request from source 1, core answers on the 50th WAIT cycle.
        req_valid = 4'b0010;
        serve_core(1, 0, 50, 1'b1, 1'b0, 0);

        // Fairness: grant 3 alone, then with only 0 and 2 pending grant 0 then 2.
        req_valid = 4'b1000;
        serve_core(3, 0, 2, 1'b0, 1'b1, 0);
        req_valid = 4'b0101;
        serve_core(0, 0, 3, 1'b1, 1'b1, 0);
        serve_core(2, 0, 4, 1'b0, 1'b0, 0);

        // Result backpressure for 20 cycles with every source still requesting.
        req_valid = 4'b1111;
        serve_core(3, 0, 5, 1'b1, 1'b0, 20);

        // core_fin_ready low for 7 ISSUE cycles, handshake on the 8th.
        serve_core(0, 7, 2, 1'b0, 1'b1, 0);

        // A dout pulse outside WAIT is ignored.
        req_valid = '0;
        core_dout_valid = 1'b1;
        core_valence = 1'b1;
        #1;
        chk("idle_dout_ready", 64'(core_dout_ready), 64'd0);
        tick();
        core_dout_valid = 1'b0;
        core_valence = 1'b0;
        chk("idle_dout_res_valid", 64'(res_valid), 64'd0);
        chk("idle_dout_busy", 64'(busy), 64'd0);

        // Reset asserted mid-WAIT clears every output at once.
        req_valid = 4'b1111;
        #1;
        chk("rstw_grant", 64'(req_ready), 64'b0010);
        tick();
        core_fin_ready = 1'b1;
        tick();
        core_fin_ready = 1'b0;
        tick();
        chk("rstw_in_wait", 64'(core_dout_ready), 64'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        tick();
        rst = 1'b1;
        serve_core(0, 0, 3, 1'b1, 1'b0, 0);

`ifdef SVM_WDOG_EN
        // Watchdog: the core never answers; abort at the 16th WAIT cycle.
        #1;
        chk("wd_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        core_fin_ready = 1'b1;
        tick();
        core_fin_ready = 1'b0;
        repeat (15) tick();
        chk("wd_pre_res_valid", 64'(res_valid), 64'd0);
        res_ready = 1'b0;
        tick();
        chk("wd_res_valid", 64'(res_valid), 64'd1);
        chk("wd_res_timeout", 64'(res_timeout), 64'd1);
        chk("wd_res_fields", {62'(res_id), res_valence, res_arousal}, {62'd1, 1'b0, 1'b0});
        chk("wd_resp_dout_ready", 64'(core_dout_ready), 64'd1);
        res_ready = 1'b1;
        tick();
        req_valid = 4'b1111;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stale_no_grant", 64'(req_ready), 64'd0);
            chk("stale_dout_ready", 64'(core_dout_ready), 64'd1);
            tick();
        end
        core_dout_valid = 1'b1;
        core_valence = 1'b1;
        tick();
        core_dout_valid = 1'b0;
        core_valence = 1'b0;
        chk("stale_cleared", 64'(core_dout_ready), 64'd0);
        chk("stale_no_result", 64'(res_valid), 64'd0);
        serve_core(2, 0, 3, 1'b1, 1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
